// File: rtl/nn_mac_sequencer_if.sv
// rtl/nn_mac_sequencer_if.sv - sample, shared-MAC and result signals of the MAC sequencer
//
// Purpose: bundles the three handshakes around nn_mac_sequencer so they travel as one port.
// Ports (signals):
//   uzorak        sample, feature k = uzorak[k*DW +: DW]
//   sample_valid  sample offered            sample_ready  sequencer idle, can accept
//   mac_x         MAC operand               w_addr        weight ROM address for the term
//   mac_en        term valid this cycle     mac_clr       first term of a neuron
//   mac_acc       MAC accumulator (in)
//   result_valid  indicators valid          result_ready  consumer takes result
//   indikator_1/2 sign bits of output neurons 0/1
// Modports: master = the sequencer, slave = sample source / MAC / result consumer side.

interface nn_mac_sequencer_if #(
    parameter int N_IN = 60,
    parameter int DW   = 16,
    parameter int AW   = 9
);
    logic [N_IN*DW-1:0] uzorak;
    logic               sample_valid;
    logic               sample_ready;
    logic [DW-1:0]      mac_x;
    logic [AW-1:0]      w_addr;
    logic               mac_en;
    logic               mac_clr;
    logic [DW-1:0]      mac_acc;
    logic               result_valid;
    logic               result_ready;
    logic               indikator_1;
    logic               indikator_2;

    modport master (
        input  uzorak, sample_valid, mac_acc, result_ready,
        output sample_ready, mac_x, w_addr, mac_en, mac_clr,
               result_valid, indikator_1, indikator_2
    );

    modport slave (
        output uzorak, sample_valid, mac_acc, result_ready,
        input  sample_ready, mac_x, w_addr, mac_en, mac_clr,
               result_valid, indikator_1, indikator_2
    );
endinterface

// File: rtl/nn_mac_sequencer.sv
// rtl/nn_mac_sequencer.sv - time-multiplexed schedule of one shared MAC through the mine-detector net
//
// Purpose: accepts one sample, drives the shared MAC/weight-ROM pair term by term through
// N_HID hidden neurons (ReLU kept internally) and 2 output neurons, then presents the two
// output sign bits until the consumer takes them.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  nn_mac_sequencer_if.master: sample handshake, MAC term bus, result handshake
// AW must be wide enough for N_HID*(N_IN+1) + 2*(N_HID+1) weight addresses.

module nn_mac_sequencer #(
    parameter int            N_IN    = 60,
    parameter int            N_HID   = 5,
    parameter int            DW      = 16,
    parameter int            MAC_LAT = 2,
    parameter logic [DW-1:0] ONE     = 'h0100,
    parameter int            AW      = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    nn_mac_sequencer_if.master      bus
);

    localparam int KMAX = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int NW   = (N_HID > 2) ? $clog2(N_HID) : 1;
    localparam int WW   = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [KW-1:0] K_HID_LAST = KW'(N_IN);
    localparam logic [KW-1:0] K_OUT_LAST = KW'(N_HID);
    localparam logic [NW-1:0] N_HID_LAST = NW'(N_HID - 1);
    localparam logic [WW-1:0] W_LAST     = WW'(MAC_LAT - 1);

    localparam int OUT_BASE = N_HID * (N_IN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HID,
        S_HWAIT,
        S_OUT,
        S_OWAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NW-1:0]       n_q, n_d;
    logic [KW-1:0]       k_q, k_d;
    logic [WW-1:0]       w_q, w_d;
    logic [N_IN*DW-1:0]  x_q;
    logic [DW-1:0]       hid_q [N_HID];
    logic                ind1_q, ind2_q;

    logic                load;
    logic                cap_hid;
    logic                cap_out;
    logic [DW-1:0]       feat_sel;
    logic [DW-1:0]       hid_sel;
    logic [DW-1:0]       relu;

    // Feature k of the latched sample; k = N_IN is never routed here (bias term takes ONE).
    assign feat_sel = x_q[int'(k_q)*DW +: DW];

    // Hidden activation k for the output layer; k = N_HID falls through to zero and is
    // replaced by ONE in the operand mux.
    always_comb begin
        hid_sel = '0;
        for (int i = 0; i < N_HID; i++) begin
            if (k_q == KW'(i)) begin
                hid_sel = hid_q[i];
            end
        end
    end

    assign relu = bus.mac_acc[DW-1] ? '0 : bus.mac_acc;

    always_comb begin
        state_d          = state_q;
        n_d              = n_q;
        k_d              = k_q;
        w_d              = w_q;
        load             = 1'b0;
        cap_hid          = 1'b0;
        cap_out          = 1'b0;
        bus.sample_ready = 1'b0;
        bus.mac_en       = 1'b0;
        bus.mac_clr      = 1'b0;
        bus.mac_x        = '0;
        bus.w_addr       = '0;
        bus.result_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.sample_ready = 1'b1;
                if (bus.sample_valid) begin
                    load    = 1'b1;
                    n_d     = '0;
                    k_d     = '0;
                    state_d = S_HID;
                end
            end

            S_HID: begin
                bus.mac_en  = 1'b1;
                bus.mac_clr = (k_q == '0);
                bus.mac_x   = (k_q == K_HID_LAST) ? ONE : feat_sel;
                bus.w_addr  = AW'(int'(n_q) * (N_IN + 1) + int'(k_q));
                if (k_q == K_HID_LAST) begin
                    k_d     = '0;
                    w_d     = '0;
                    state_d = S_HWAIT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            // mac_acc only holds the full neuron sum on the last wait cycle.
            S_HWAIT: begin
                if (w_q == W_LAST) begin
                    cap_hid = 1'b1;
                    if (n_q == N_HID_LAST) begin
                        n_d     = '0;
                        state_d = S_OUT;
                    end else begin
                        n_d     = n_q + NW'(1);
                        state_d = S_HID;
                    end
                end else begin
                    w_d = w_q + WW'(1);
                end
            end

            S_OUT: begin
                bus.mac_en  = 1'b1;
                bus.mac_clr = (k_q == '0);
                bus.mac_x   = (k_q == K_OUT_LAST) ? ONE : hid_sel;
                bus.w_addr  = AW'(OUT_BASE + int'(n_q) * (N_HID + 1) + int'(k_q));
                if (k_q == K_OUT_LAST) begin
                    k_d     = '0;
                    w_d     = '0;
                    state_d = S_OWAIT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            S_OWAIT: begin
                if (w_q == W_LAST) begin
                    cap_out = 1'b1;
                    if (n_q == '0) begin
                        n_d     = NW'(1);
                        state_d = S_OUT;
                    end else begin
                        n_d     = '0;
                        state_d = S_DONE;
                    end
                end else begin
                    w_d = w_q + WW'(1);
                end
            end

            // sample_ready stays low here, giving a one-cycle bubble before the next accept.
            S_DONE: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            w_q     <= '0;
            x_q     <= '0;
            ind1_q  <= 1'b0;
            ind2_q  <= 1'b0;
            for (int i = 0; i < N_HID; i++) begin
                hid_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            w_q     <= w_d;
            if (load) begin
                x_q <= bus.uzorak;
            end
            for (int i = 0; i < N_HID; i++) begin
                if (cap_hid && (n_q == NW'(i))) begin
                    hid_q[i] <= relu;
                end
            end
            if (cap_out) begin
                if (n_q == '0) begin
                    ind1_q <= bus.mac_acc[DW-1];
                end else begin
                    ind2_q <= bus.mac_acc[DW-1];
                end
            end
        end
    end

    assign bus.indikator_1 = ind1_q;
    assign bus.indikator_2 = ind2_q;

endmodule
